// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits + odd parity + stop, then ACK check.
// Optional macro PS2_TX_RETRY_EN: one automatic re-send of the latched byte after a NACK or timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK} state_t;

    state_t             state_q, state_d;
    logic [9:0]         frame_q, frame_d;
    logic [3:0]         bitCnt_q, bitCnt_d;
    logic [INH_W-1:0]   inhCnt_q, inhCnt_d;
    logic [WD_W-1:0]    wdCnt_q, wdCnt_d;
    logic               clkOe_q, clkOe_d;
    logic               dataOe_q, dataOe_d;
    logic [SYNC_STAGES-1:0] clkSync_q, dataSync_q;
    logic               clkPrev_q;
`ifdef PS2_TX_RETRY_EN
    logic               retry_q, retry_d;
`endif

    logic clkSynced, dataSynced, clkFall;
    logic doneNow, errNow, failNow;
    logic [3:0] nextBit;

    assign clkSynced  = clkSync_q[SYNC_STAGES-1];
    assign dataSynced = dataSync_q[SYNC_STAGES-1];
    assign clkFall    = clkPrev_q & ~clkSynced;

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        bitCnt_d = bitCnt_q;
        inhCnt_d = inhCnt_q;
        wdCnt_d  = wdCnt_q;
        clkOe_d  = clkOe_q;
        dataOe_d = dataOe_q;
        doneNow  = 1'b0;
        errNow   = 1'b0;
        failNow  = 1'b0;
        nextBit  = bitCnt_q + 4'd1;
`ifdef PS2_TX_RETRY_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            IDLE: begin
                clkOe_d  = 1'b0;
                dataOe_d = 1'b0;
                if (tx_valid) begin
                    frame_d  = {1'b1, ~^tx_data, tx_data};
                    inhCnt_d = '0;
                    bitCnt_d = 4'd0;
                    clkOe_d  = 1'b1;
                    state_d  = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d  = 1'b0;
`endif
                end
            end
            INHIBIT: begin
                if (inhCnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    state_d  = REQ;
                    clkOe_d  = 1'b0;
                    dataOe_d = 1'b1;
                    wdCnt_d  = '0;
                end else begin
                    inhCnt_d = inhCnt_q + INH_W'(1);
                end
            end
            REQ, SEND, ACK: begin
                // The watchdog wins over a fall arriving in the same cycle.
                if (wdCnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    failNow = 1'b1;
                end else if (clkFall) begin
                    wdCnt_d = '0;
                    if (state_q == ACK) begin
                        bitCnt_d = 4'd11;
                        if (dataSynced) failNow = 1'b1;
                        else            doneNow = 1'b1;
                    end else begin
                        dataOe_d = ~frame_q[bitCnt_q];
                        bitCnt_d = nextBit;
                        state_d  = (nextBit == 4'd10) ? ACK : SEND;
                    end
                end else begin
                    wdCnt_d = wdCnt_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (doneNow) begin
            state_d  = IDLE;
            clkOe_d  = 1'b0;
            dataOe_d = 1'b0;
        end
        if (failNow) begin
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
                retry_d  = 1'b1;
                state_d  = INHIBIT;
                inhCnt_d = '0;
                bitCnt_d = 4'd0;
                clkOe_d  = 1'b1;
                dataOe_d = 1'b0;
            end else begin
                errNow   = 1'b1;
                state_d  = IDLE;
                clkOe_d  = 1'b0;
                dataOe_d = 1'b0;
            end
`else
            errNow   = 1'b1;
            state_d  = IDLE;
            clkOe_d  = 1'b0;
            dataOe_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            bitCnt_q   <= 4'd0;
            inhCnt_q   <= '0;
            wdCnt_q    <= '0;
            clkOe_q    <= 1'b0;
            dataOe_q   <= 1'b0;
            clkSync_q  <= '1;
            dataSync_q <= '1;
            clkPrev_q  <= 1'b1;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bitCnt_q   <= bitCnt_d;
            inhCnt_q   <= inhCnt_d;
            wdCnt_q    <= wdCnt_d;
            clkOe_q    <= clkOe_d;
            dataOe_q   <= dataOe_d;
            clkSync_q  <= {clkSync_q[SYNC_STAGES-2:0], ps2_clk_in};
            dataSync_q <= {dataSync_q[SYNC_STAGES-2:0], ps2_data_in};
            clkPrev_q  <= clkSynced;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    assign tx_ready    = (state_q == IDLE);
    assign busy        = ~tx_ready;
    assign done        = doneNow & ~reset;
    assign err         = errNow & ~reset;
    assign ps2_clk_oe  = clkOe_q;
    assign ps2_data_oe = dataOe_q;

endmodule
